// File: rtl/rv32i_gcd_host_if.sv
// Request/response handshake bundle between a GCD job source (master) and rv32i_gcd_host (slave).
interface rv32i_gcd_host_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_err
    );
endinterface

// File: rtl/rv32i_gcd_host.sv
// Job controller for the rv32i_cpu GCD port: parks/resets the CPU, runs one job, filters gcd_result for stability.
// GCD_HOST_TIMEOUT_EN adds a RUN-state cycle limit (MAX_CYCLES, only declared with the macro) reported via rsp_err.
module rv32i_gcd_host #(
    parameter int RST_CYCLES    = 2,
    parameter int STABLE_CYCLES = 8
`ifdef GCD_HOST_TIMEOUT_EN
    , parameter int MAX_CYCLES  = 4096
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rv32i_gcd_host_if.slave       bus,
    output logic                  busy,
    output logic                  cpu_rst_n,
    output logic                  calc_start,
    output logic [31:0]           gcd_a,
    output logic [31:0]           gcd_b,
    input  logic [31:0]           gcd_result
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RST = 2'd1,
        RUN     = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam int RST_N   = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
    localparam int STB_N   = (STABLE_CYCLES < 2) ? 2 : STABLE_CYCLES;
    localparam int CNT_MAX = (RST_N > STB_N) ? RST_N : STB_N;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_N - 1);
    // Counter value on the cycle whose stable sample makes STB_N consecutive equal nonzero reads.
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STB_N - 2);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       prev_q, prev_d;
    logic [31:0]       gcd_a_q, gcd_a_d;
    logic [31:0]       gcd_b_q, gcd_b_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              calc_start_q, calc_start_d;
    logic              stable_s;

`ifdef GCD_HOST_TIMEOUT_EN
    localparam int MAX_N = (MAX_CYCLES < 1) ? 1 : MAX_CYCLES;
    localparam int RUN_W = $clog2(MAX_N + 1);
    localparam logic [RUN_W-1:0] MAX_LAST = RUN_W'(MAX_N - 1);
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic              rsp_err_q, rsp_err_d;
`endif

    // Next-state and next-output computation for the job FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        gcd_a_d      = gcd_a_q;
        gcd_b_d      = gcd_b_q;
        rsp_result_d = rsp_result_q;
        rsp_valid_d  = rsp_valid_q;
        busy_d       = busy_q;
        cpu_rst_n_d  = cpu_rst_n_q;
        calc_start_d = calc_start_q;
        stable_s     = (gcd_result != 32'd0) && (gcd_result == prev_q);
`ifdef GCD_HOST_TIMEOUT_EN
        run_cnt_d    = run_cnt_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    gcd_a_d = bus.req_a;
                    gcd_b_d = bus.req_b;
                    busy_d  = 1'b1;
`ifdef GCD_HOST_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                    if ((bus.req_a == 32'd0) || (bus.req_b == 32'd0)) begin
                        rsp_result_d = bus.req_a | bus.req_b;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end else begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = CPU_RST;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CPU_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d        = {CNT_W{1'b0}};
                    prev_d       = 32'd0;
                    cpu_rst_n_d  = 1'b1;
                    calc_start_d = 1'b1;
                    state_d      = RUN;
`ifdef GCD_HOST_TIMEOUT_EN
                    run_cnt_d    = {RUN_W{1'b0}};
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                prev_d = gcd_result;
                if (stable_s && (cnt_q == STB_LAST)) begin
                    rsp_result_d = gcd_result;
                    rsp_valid_d  = 1'b1;
                    cpu_rst_n_d  = 1'b0;
                    calc_start_d = 1'b0;
                    state_d      = RESP;
                end else begin
                    if (stable_s) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = {CNT_W{1'b0}};
                    end
`ifdef GCD_HOST_TIMEOUT_EN
                    if (run_cnt_q == MAX_LAST) begin
                        rsp_result_d = 32'd0;
                        rsp_err_d    = 1'b1;
                        rsp_valid_d  = 1'b1;
                        cpu_rst_n_d  = 1'b0;
                        calc_start_d = 1'b0;
                        state_d      = RESP;
                    end else begin
                        run_cnt_d = run_cnt_q + RUN_W'(1);
                    end
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d  = 1'b0;
                busy_d       = 1'b0;
                cpu_rst_n_d  = 1'b0;
                calc_start_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            prev_q       <= 32'd0;
            gcd_a_q      <= 32'd0;
            gcd_b_q      <= 32'd0;
            rsp_result_q <= 32'd0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
            calc_start_q <= 1'b0;
`ifdef GCD_HOST_TIMEOUT_EN
            run_cnt_q    <= {RUN_W{1'b0}};
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            gcd_a_q      <= gcd_a_d;
            gcd_b_q      <= gcd_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            calc_start_q <= calc_start_d;
`ifdef GCD_HOST_TIMEOUT_EN
            run_cnt_q    <= run_cnt_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    // req_ready is masked while reset is asserted so nothing looks acceptable during reset.
    assign bus.req_ready  = rst_n & (state_q == IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
`ifdef GCD_HOST_TIMEOUT_EN
    assign bus.rsp_err    = rsp_err_q;
`else
    assign bus.rsp_err    = 1'b0;
`endif
    assign busy       = busy_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign calc_start = calc_start_q;
    assign gcd_a      = gcd_a_q;
    assign gcd_b      = gcd_b_q;

endmodule

// File: tb/tb_rv32i_gcd_host.sv
// Self-checking bench for rv32i_gcd_host: vector table of jobs plus directed stability, backpressure, reset and timeout sequences.
module tb_rv32i_gcd_host;

    localparam int RST_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy, cpu_rst_n, calc_start;
    logic [31:0] gcd_a, gcd_b, gcd_result;

    rv32i_gcd_host_if bus();

    rv32i_gcd_host #(
        .RST_CYCLES(RST_CYCLES),
        .STABLE_CYCLES(8)
`ifdef GCD_HOST_TIMEOUT_EN
        , .MAX_CYCLES(64)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy),
        .cpu_rst_n(cpu_rst_n),
        .calc_start(calc_start),
        .gcd_a(gcd_a),
        .gcd_b(gcd_b),
        .gcd_result(gcd_result)
    );

    always #5 clk = ~clk;

    // Behavioural CPU: subtractive Euclid, result published once x==y; script mode overrides the output.
    logic        script_mode;
    logic [31:0] script_val;
    logic [31:0] mx, my, mres;
    logic        loaded;
    always @(posedge clk) begin
        if (!cpu_rst_n) begin
            mx <= 32'd0; my <= 32'd0; mres <= 32'd0; loaded <= 1'b0;
        end else if (calc_start) begin
            if (!loaded) begin
                mx <= gcd_a; my <= gcd_b; loaded <= 1'b1;
            end else if (mx > my) begin
                mx <= mx - my;
            end else if (my > mx) begin
                my <= my - mx;
            end else begin
                mres <= mx;
            end
        end
    end
    assign gcd_result = script_mode ? script_val : mres;

    int n_cmp = 0;
    int n_bad = 0;
    int tag   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL [%0d] %s: got %0d expected %0d", tag, name, act, exp);
        end
    endtask

    // Present a request and return at the negedge just after the accepting edge.
    task automatic send_req(input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        chk("req_ready_wait", bus.req_ready, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (cpu_rst_n !== 1'b1 && n < 50) begin
            @(negedge clk); n++;
        end
        chk("reach_run", cpu_rst_n, 32'd1);
    endtask

    task automatic ack_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", bus.rsp_valid, 32'd0);
        chk("req_ready_back", bus.req_ready, 32'd1);
        chk("busy_drop", busy, 32'd0);
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                           input logic zero);
        int lows, n;
        logic run_ok;
        send_req(a, b);
        if (zero) begin
            chk("zero_rsp_valid", bus.rsp_valid, 32'd1);
            chk("zero_cpu_rst_n", cpu_rst_n, 32'd0);
        end else begin
            lows = 0;
            while (cpu_rst_n == 1'b0 && lows < 50) begin
                lows++; @(negedge clk);
            end
            chk("cpu_rst_low_cycles", lows, RST_CYCLES);
            chk("calc_start_run", calc_start, 32'd1);
            chk("gcd_a", gcd_a, a);
            chk("gcd_b", gcd_b, b);
            n = 0; run_ok = 1'b1;
            while (bus.rsp_valid !== 1'b1 && n < 5000) begin
                if (calc_start !== 1'b1 || cpu_rst_n !== 1'b1) run_ok = 1'b0;
                @(negedge clk); n++;
            end
            chk("rsp_valid_wait", bus.rsp_valid, 32'd1);
            chk("run_levels_held", run_ok, 32'd1);
            chk("cpu_parked_resp", cpu_rst_n, 32'd0);
            chk("calc_start_resp", calc_start, 32'd0);
        end
        chk("rsp_result", bus.rsp_result, exp);
        chk("rsp_err", bus.rsp_err, 32'd0);
        ack_rsp();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        zero;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'd0,    32'd21,  32'd21, 1'b1};
        vecs[1] = '{32'd0,    32'd0,   32'd0,  1'b1};
        vecs[2] = '{32'd35,   32'd0,   32'd35, 1'b1};
        vecs[3] = '{32'd48,   32'd18,  32'd6,  1'b0};
        vecs[4] = '{32'd1071, 32'd462, 32'd21, 1'b0};
        vecs[5] = '{32'd9,    32'd6,   32'd3,  1'b0};
        vecs[6] = '{32'd7,    32'd7,   32'd7,  1'b0};
        vecs[7] = '{32'd17,   32'd5,   32'd1,  1'b0};
        vecs[8] = '{32'd100,  32'd75,  32'd25, 1'b0};

        rst_n = 1'b0; script_mode = 1'b0; script_val = 32'd0;
        bus.req_valid = 1'b0; bus.req_a = 32'd0; bus.req_b = 32'd0; bus.rsp_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 32'd0);
        chk("rst_rsp_valid", bus.rsp_valid, 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_rsp_err", bus.rsp_err, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_cpu_rst_n", cpu_rst_n, 32'd0);
        chk("rst_calc_start", calc_start, 32'd0);
        chk("rst_gcd_a", gcd_a, 32'd0);
        chk("rst_gcd_b", gcd_b, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", bus.req_ready, 32'd1);
        chk("post_rst_busy", busy, 32'd0);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            tag = i;
            run_job(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].zero);
        end

        // Stability filter: 12 x2, 6 x3, then 3 steady
        tag = 100;
        script_mode = 1'b1; script_val = 32'd0;
        send_req(32'd12, 32'd9);
        wait_run();
        script_val = 32'd12;
        repeat (2) begin @(negedge clk); chk("stab_no_early_12", bus.rsp_valid, 32'd0); end
        script_val = 32'd6;
        repeat (3) begin @(negedge clk); chk("stab_no_early_6", bus.rsp_valid, 32'd0); end
        script_val = 32'd3;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("stab_rsp_timing", bus.rsp_valid, (i == 8) ? 32'd1 : 32'd0);
        end
        chk("stab_result", bus.rsp_result, 32'd3);
        ack_rsp();
        script_mode = 1'b0;

        // Backpressure with a pending request
        tag = 200;
        send_req(32'd5, 32'd0);
        chk("bp_rsp_valid_first", bus.rsp_valid, 32'd1);
        bus.req_valid = 1'b1; bus.req_a = 32'd0; bus.req_b = 32'd7;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", bus.rsp_valid, 32'd1);
            chk("bp_rsp_result", bus.rsp_result, 32'd5);
            chk("bp_rsp_err", bus.rsp_err, 32'd0);
            chk("bp_req_ready", bus.req_ready, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("bp_exit_rsp_valid", bus.rsp_valid, 32'd0);
        chk("bp_exit_req_ready", bus.req_ready, 32'd1);
        chk("bp_exit_busy", busy, 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("bp_pending_rsp", bus.rsp_valid, 32'd1);
        chk("bp_pending_result", bus.rsp_result, 32'd7);
        ack_rsp();

        // Reset mid-RUN, then a normal job
        tag = 300;
        send_req(32'd48, 32'd18);
        wait_run();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_cpu_rst_n", cpu_rst_n, 32'd0);
        chk("mid_rst_calc_start", calc_start, 32'd0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_req_ready", bus.req_ready, 32'd1);
        run_job(32'd9, 32'd6, 32'd3, 1'b0);

        // Result stuck at zero
        tag = 400;
        script_mode = 1'b1; script_val = 32'd0;
        send_req(32'd4, 32'd6);
        wait_run();
`ifdef GCD_HOST_TIMEOUT_EN
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (i >= 63) chk("to_rsp_timing", bus.rsp_valid, (i == 64) ? 32'd1 : 32'd0);
        end
        chk("to_rsp_err", bus.rsp_err, 32'd1);
        chk("to_rsp_result", bus.rsp_result, 32'd0);
        ack_rsp();
`else
        repeat (200) @(negedge clk);
        chk("no_to_busy", busy, 32'd1);
        chk("no_to_rsp_valid", bus.rsp_valid, 32'd0);
        chk("no_to_rsp_err", bus.rsp_err, 32'd0);
        chk("no_to_calc_start", calc_start, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("no_to_abort_busy", busy, 32'd0);
`endif
        script_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
